// File: rtl/core_v_mini_mcu_pkg.sv
// MCU-level constants; arbitration mode encodings for the OBI arbiter.
package core_v_mini_mcu_pkg;

  localparam int unsigned ARB_MODE_RR    = 0;
  localparam int unsigned ARB_MODE_FIXED = 1;

endpackage

// File: rtl/obi_pkg.sv
// OBI bus payload types shared by masters, the arbiter and the downstream slave.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/mochila_id_fifo.sv
// In-order ID FIFO; depth need not be a power of two, pointers wrap explicitly.
module mochila_id_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wrap_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= wrap_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mochila_obi_arbiter.sv
// N-to-1 OBI arbiter: round-robin or fixed priority, address-phase lock,
// in-order rvalid routing via an ID FIFO, sticky error on orphan rvalid.
module mochila_obi_arbiter
  import obi_pkg::*;
  import core_v_mini_mcu_pkg::*;
#(
  parameter int unsigned NMASTERS        = 3,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ARB_MODE        = ARB_MODE_RR
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  obi_req_t                             master_req_i  [NMASTERS],
  output obi_resp_t                            master_resp_o [NMASTERS],
  output obi_req_t                             slave_req_o,
  input  obi_resp_t                            slave_resp_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_o
);

  localparam int unsigned IDX_W = $clog2(NMASTERS);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING+1);

  logic [IDX_W-1:0] rr_ptr_q, lock_idx_q, start, cand, arb_idx, sel, head;
  logic             lock_q, any_req, found, fwd_req, handshake, pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] count;

  // Handshake: address phase completes when slave_req_o.req & slave_resp_i.gnt
  // are both high at a rising edge; a pending request keeps its master (and its
  // payload) stable until then. Response phase is one rvalid per accepted
  // request, returned strictly in acceptance order.
  always_comb begin
    start   = (ARB_MODE == ARB_MODE_FIXED) ? '0 : rr_ptr_q;
    cand    = '0;
    arb_idx = '0;
    found   = 1'b0;
    any_req = 1'b0;
    for (int k = 0; k < int'(NMASTERS); k++) begin
      cand = IDX_W'((int'(start) + k) % int'(NMASTERS));
      if (!found && master_req_i[cand].req) begin
        arb_idx = cand;
        found   = 1'b1;
      end
      any_req = any_req | master_req_i[k].req;
    end
  end

  assign sel       = lock_q ? lock_idx_q : arb_idx;
  assign fwd_req   = rst_ni & any_req & ~fifo_full;
  assign handshake = slave_req_o.req & slave_resp_i.gnt;
  assign pop       = slave_resp_i.rvalid & ~fifo_empty;

  always_comb begin
    slave_req_o = '0;
    if (fwd_req) slave_req_o = master_req_i[sel];
  end

  // Only the FIFO head sees the response; everyone else is driven to zero.
  always_comb begin
    for (int i = 0; i < int'(NMASTERS); i++) begin
      master_resp_o[i].gnt    = handshake && (sel == IDX_W'(i));
      master_resp_o[i].rvalid = pop && (head == IDX_W'(i));
      master_resp_o[i].rdata  = (pop && (head == IDX_W'(i))) ? slave_resp_i.rdata : '0;
    end
  end

  // A full FIFO drops req, which also releases the lock so selection re-runs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_o      <= 1'b0;
    end else begin
      lock_q     <= slave_req_o.req & ~slave_resp_i.gnt;
      lock_idx_q <= sel;
      if (handshake) rr_ptr_q <= (sel == IDX_W'(NMASTERS-1)) ? '0 : sel + IDX_W'(1);
      if (slave_resp_i.rvalid && fifo_empty) err_o <= 1'b1;
    end
  end

  mochila_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (handshake),
    .wdata  (sel),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (count),
    .head   (head)
  );

  assign outstanding_o = count;

endmodule

// File: tb/tb_mochila_obi_arbiter.sv
// Directed bench: round-robin instance (defaults) and fixed-priority instance
// (MAX_OUTSTANDING=2) driven by the same master/slave stimulus.
module tb_mochila_obi_arbiter;
  import obi_pkg::*;

  logic      clk;
  logic      rst_ni;
  obi_req_t  m_req [3];
  obi_resp_t s_resp;

  obi_resp_t rr_resp [3];
  obi_req_t  rr_sreq;
  logic [2:0] rr_out;
  logic      rr_err;

  obi_resp_t fp_resp [3];
  obi_req_t  fp_sreq;
  logic [1:0] fp_out;
  logic      fp_err;

  logic [2:0] rr_gnt, rr_rv, fp_gnt, fp_rv;

  int n_vec;
  int n_miscmp;

  mochila_obi_arbiter u_rr (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .master_req_i  (m_req),
    .master_resp_o (rr_resp),
    .slave_req_o   (rr_sreq),
    .slave_resp_i  (s_resp),
    .outstanding_o (rr_out),
    .err_o         (rr_err)
  );

  mochila_obi_arbiter #(
    .NMASTERS        (3),
    .MAX_OUTSTANDING (2),
    .ARB_MODE        (1)
  ) u_fp (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .master_req_i  (m_req),
    .master_resp_o (fp_resp),
    .slave_req_o   (fp_sreq),
    .slave_resp_i  (s_resp),
    .outstanding_o (fp_out),
    .err_o         (fp_err)
  );

  assign rr_gnt = {rr_resp[2].gnt,    rr_resp[1].gnt,    rr_resp[0].gnt};
  assign rr_rv  = {rr_resp[2].rvalid, rr_resp[1].rvalid, rr_resp[0].rvalid};
  assign fp_gnt = {fp_resp[2].gnt,    fp_resp[1].gnt,    fp_resp[0].gnt};
  assign fp_rv  = {fp_resp[2].rvalid, fp_resp[1].rvalid, fp_resp[0].rvalid};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic set_req(input int m, input logic r, input logic [31:0] a, input logic [31:0] d);
    m_req[m].req   = r;
    m_req[m].we    = 1'b1;
    m_req[m].be    = 4'hF;
    m_req[m].addr  = a;
    m_req[m].wdata = d;
  endtask

  task automatic set_slave(input logic g, input logic rv, input logic [31:0] rd);
    s_resp.gnt    = g;
    s_resp.rvalid = rv;
    s_resp.rdata  = rd;
  endtask

  task automatic clear_inputs;
    for (int m = 0; m < 3; m++) set_req(m, 1'b0, 32'h0, 32'h0);
    set_slave(1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset;
    rst_ni = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rr_out", 32'(rr_out), 32'd0);
    chk("rst_fp_out", 32'(fp_out), 32'd0);
    chk("rst_rr_err", 32'(rr_err), 32'd0);
    chk("rst_fp_err", 32'(fp_err), 32'd0);
    rst_ni = 1'b1;
  endtask

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    rst_ni   = 1'b0;
    clear_inputs();

    // Reset holds the slave port quiet even with requests and grant present.
    set_req(0, 1'b1, 32'h10, 32'h0);
    set_req(2, 1'b1, 32'h30, 32'h0);
    set_slave(1'b1, 1'b0, 32'h0);
    #2;
    chk("rst_sreq_req", 32'(rr_sreq.req), 32'd0);
    chk("rst_rr_gnt", 32'(rr_gnt), 32'd0);
    chk("rst_fp_gnt", 32'(fp_gnt), 32'd0);
    do_reset();

    // Round-robin alternation between masters 0 and 2, then in-order rvalid.
    set_req(0, 1'b1, 32'h1000, 32'h0);
    set_req(2, 1'b1, 32'h3000, 32'h0);
    set_slave(1'b1, 1'b0, 32'h0);
    settle();
    chk("rr_g1", 32'(rr_gnt), 32'b001);
    chk("rr_addr1", rr_sreq.addr, 32'h1000);
    tick();
    chk("rr_g2", 32'(rr_gnt), 32'b100);
    chk("rr_addr2", rr_sreq.addr, 32'h3000);
    tick();
    chk("rr_g3", 32'(rr_gnt), 32'b001);
    tick();
    chk("rr_g4", 32'(rr_gnt), 32'b100);
    tick();
    chk("rr_full_req", 32'(rr_sreq.req), 32'd0);
    chk("rr_full_gnt", 32'(rr_gnt), 32'd0);
    chk("rr_full_out", 32'(rr_out), 32'd4);
    clear_inputs();
    set_slave(1'b0, 1'b1, 32'hA0);
    settle();
    chk("rr_rv1", 32'(rr_rv), 32'b001);
    chk("rr_rd1", rr_resp[0].rdata, 32'hA0);
    tick();
    set_slave(1'b0, 1'b1, 32'hA1);
    settle();
    chk("rr_rv2", 32'(rr_rv), 32'b100);
    chk("rr_rd2", rr_resp[2].rdata, 32'hA1);
    chk("rr_rd2_other", rr_resp[0].rdata, 32'h0);
    tick();
    chk("rr_rv3", 32'(rr_rv), 32'b001);
    tick();
    chk("rr_rv4", 32'(rr_rv), 32'b100);
    tick();
    set_slave(1'b0, 1'b0, 32'h0);
    settle();
    chk("rr_drain_out", 32'(rr_out), 32'd0);
    chk("rr_drain_err", 32'(rr_err), 32'd0);

    // Address-phase lock: master 1 waits 3 cycles, master 0 joins in cycle 2.
    do_reset();
    set_req(1, 1'b1, 32'h2000, 32'h1111);
    settle();
    chk("lk_c1_gnt", 32'(rr_gnt), 32'd0);
    chk("lk_c1_addr", rr_sreq.addr, 32'h2000);
    tick();
    set_req(0, 1'b1, 32'h1004, 32'h0);
    settle();
    chk("lk_c2_addr", rr_sreq.addr, 32'h2000);
    chk("lk_c2_wdata", rr_sreq.wdata, 32'h1111);
    tick();
    chk("lk_c3_addr", rr_sreq.addr, 32'h2000);
    chk("lk_c3_gnt", 32'(rr_gnt), 32'd0);
    tick();
    set_slave(1'b1, 1'b0, 32'h0);
    settle();
    chk("lk_c4_gnt", 32'(rr_gnt), 32'b010);
    chk("lk_c4_addr", rr_sreq.addr, 32'h2000);
    tick();
    set_req(1, 1'b0, 32'h0, 32'h0);
    settle();
    chk("lk_c5_gnt", 32'(rr_gnt), 32'b001);
    chk("lk_c5_addr", rr_sreq.addr, 32'h1004);
    chk("lk_c5_out", 32'(rr_out), 32'd1);

    // Outstanding limit of 2 on the fixed-priority instance.
    do_reset();
    set_req(0, 1'b1, 32'h100, 32'h0);
    set_req(1, 1'b1, 32'h200, 32'h0);
    set_req(2, 1'b1, 32'h300, 32'h0);
    set_slave(1'b1, 1'b0, 32'h0);
    settle();
    chk("lim_g1", 32'(fp_gnt), 32'b001);
    tick();
    set_req(0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("lim_g2", 32'(fp_gnt), 32'b010);
    tick();
    set_req(1, 1'b0, 32'h0, 32'h0);
    settle();
    chk("lim_blk_gnt", 32'(fp_gnt), 32'd0);
    chk("lim_blk_req", 32'(fp_sreq.req), 32'd0);
    chk("lim_out2", 32'(fp_out), 32'd2);
    tick();
    chk("lim_blk2_gnt", 32'(fp_gnt), 32'd0);
    set_slave(1'b1, 1'b1, 32'h55);
    settle();
    chk("lim_pop_rv", 32'(fp_rv), 32'b001);
    chk("lim_pop_rd", fp_resp[0].rdata, 32'h55);
    chk("lim_pop_gnt", 32'(fp_gnt), 32'd0);
    tick();
    set_slave(1'b1, 1'b0, 32'h0);
    settle();
    chk("lim_g3", 32'(fp_gnt), 32'b100);
    chk("lim_out1", 32'(fp_out), 32'd1);
    tick();
    chk("lim_out_back2", 32'(fp_out), 32'd2);

    // Simultaneous push and pop at count 1.
    do_reset();
    set_req(1, 1'b1, 32'h2100, 32'h0);
    set_slave(1'b1, 1'b0, 32'h0);
    settle();
    chk("pp_g1", 32'(rr_gnt), 32'b010);
    tick();
    set_req(1, 1'b0, 32'h0, 32'h0);
    set_req(2, 1'b1, 32'h3100, 32'h0);
    set_slave(1'b1, 1'b1, 32'hDEADBEEF);
    settle();
    chk("pp_g2", 32'(rr_gnt), 32'b100);
    chk("pp_rv", 32'(rr_rv), 32'b010);
    chk("pp_rd1", rr_resp[1].rdata, 32'hDEADBEEF);
    chk("pp_rd0", rr_resp[0].rdata, 32'h0);
    chk("pp_rd2", rr_resp[2].rdata, 32'h0);
    tick();
    clear_inputs();
    settle();
    chk("pp_out", 32'(rr_out), 32'd1);
    set_slave(1'b0, 1'b1, 32'h12345678);
    settle();
    chk("pp_rv2", 32'(rr_rv), 32'b100);
    chk("pp_rd2b", rr_resp[2].rdata, 32'h12345678);
    tick();

    // Orphan rvalid on an empty FIFO sets the sticky error.
    set_slave(1'b0, 1'b1, 32'hAA);
    settle();
    chk("err_rv", 32'(rr_rv), 32'd0);
    chk("err_rd0", rr_resp[0].rdata, 32'h0);
    chk("err_same_cyc", 32'(rr_err), 32'd0);
    tick();
    set_slave(1'b0, 1'b0, 32'h0);
    settle();
    chk("err_set", 32'(rr_err), 32'd1);
    set_req(0, 1'b1, 32'h1200, 32'h0);
    set_slave(1'b1, 1'b0, 32'h0);
    settle();
    chk("err_g", 32'(rr_gnt), 32'b001);
    tick();
    clear_inputs();
    tick();
    chk("err_hold", 32'(rr_err), 32'd1);
    chk("err_out", 32'(rr_out), 32'd1);

    // Fixed priority with all three masters requesting.
    do_reset();
    set_req(0, 1'b1, 32'h100, 32'h0);
    set_req(1, 1'b1, 32'h200, 32'h0);
    set_req(2, 1'b1, 32'h300, 32'h0);
    set_slave(1'b1, 1'b0, 32'h0);
    settle();
    chk("fp_g0", 32'(fp_gnt), 32'b001);
    tick();
    set_slave(1'b1, 1'b1, 32'h0);
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("fp_g_loop", 32'(fp_gnt), 32'b001);
      chk("fp_rv_loop", 32'(fp_rv), 32'b001);
      chk("fp_out_loop", 32'(fp_out), 32'd1);
      tick();
    end
    set_req(0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("fp_g1", 32'(fp_gnt), 32'b010);
    chk("fp_rv_h0", 32'(fp_rv), 32'b001);
    tick();
    set_req(1, 1'b0, 32'h0, 32'h0);
    settle();
    chk("fp_g2", 32'(fp_gnt), 32'b100);
    chk("fp_rv_h1", 32'(fp_rv), 32'b010);
    chk("fp_no_err", 32'(fp_err), 32'd0);
    tick();

    // Reset mid-transaction drops outstanding IDs; later rvalid is orphaned.
    rst_ni = 1'b0;
    settle();
    chk("mid_rst_out", 32'(fp_out), 32'd0);
    chk("mid_rst_req", 32'(fp_sreq.req), 32'd0);
    chk("mid_rst_gnt", 32'(fp_gnt), 32'd0);
    tick();
    rst_ni = 1'b1;
    clear_inputs();
    set_slave(1'b0, 1'b1, 32'h77);
    settle();
    chk("mid_rst_rv", 32'(fp_rv), 32'd0);
    tick();
    set_slave(1'b0, 1'b0, 32'h0);
    settle();
    chk("mid_rst_err", 32'(fp_err), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/mochila_obi_arbiter.md
MOCHILA_OBI_ARBITER -- requirements
Module: mochila_obi_arbiter

Interface
REQ-001 Parameter NMASTERS, default 3: number of OBI master ports, legal range 2..8.
REQ-002 Parameter MAX_OUTSTANDING, default 4: maximum number of granted transactions awaiting rvalid, legal range 1..16.
REQ-003 Parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 Port clk_i, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-006 Port master_req_i, input, obi_req_t [NMASTERS]: OBI requests (req, we, be, addr, wdata).
REQ-007 Port master_resp_o, output, obi_resp_t [NMASTERS]: OBI responses (gnt, rvalid, rdata).
REQ-008 Port slave_req_o, output, obi_req_t: the single arbitrated downstream request.
REQ-009 Port slave_resp_i, input, obi_resp_t: downstream response.
REQ-010 Port outstanding_o, output, $clog2(MAX_OUTSTANDING+1) bits: current outstanding count.
REQ-011 Port err_o, output, 1: sticky flag for an unexpected rvalid.

Function
REQ-012 Selection, ARB_MODE=0: choose the first requesting master found searching upward (with wrap) from rr_ptr.
REQ-013 Selection, ARB_MODE=1: choose the lowest-index requesting master.
REQ-014 Lock: while slave_req_o.req=1 and slave_resp_i.gnt=0, the selected index is held in a lock register; selection is not re-evaluated until the grant (OBI address-phase stability).
REQ-015 slave_req_o SHALL equal master_req_i[sel] when any master requests and count < MAX_OUTSTANDING; otherwise slave_req_o.req=0 and all other fields are 0.
REQ-016 master_resp_o[i].gnt = slave_resp_i.gnt AND slave_req_o.req AND (sel == i); gnt is combinational, zero added latency.
REQ-017 On handshake (slave_req_o.req & slave_resp_i.gnt): push sel into the in-order ID FIFO (depth MAX_OUTSTANDING), clear the lock, and set rr_ptr = (sel+1) mod NMASTERS.
REQ-018 rr_ptr is updated only on a handshake; in ARB_MODE=1 it is still updated but not used.
REQ-019 On slave_resp_i.rvalid with FIFO non-empty: pop the head; master_resp_o[head].rvalid=1 and rdata=slave_resp_i.rdata in the same cycle; every other master sees rvalid=0 and rdata=0.
REQ-020 On slave_resp_i.rvalid with FIFO empty: no master sees rvalid, the response is dropped, and err_o is set to 1 and held until reset.
REQ-021 Simultaneous push and pop in one cycle: the count is unchanged and FIFO order is preserved.
REQ-022 Full (count == MAX_OUTSTANDING): new requests are blocked even if a pop occurs in the same cycle; a request is issued again on the next cycle.
REQ-023 Full blocking clears any lock and lets selection re-evaluate, because no request is forwarded downstream.
REQ-024 FIFO read and write pointers wrap modulo MAX_OUTSTANDING, which may be a non-power-of-2.
REQ-025 outstanding_o equals the FIFO count, registered.

Reset
REQ-026 rst_ni low: rr_ptr=0, lock cleared, FIFO pointers and count=0, err_o=0, all gnt/rvalid outputs 0, slave_req_o.req=0.
REQ-027 Reset asserted mid-transaction discards all outstanding IDs; responses arriving after reset are treated per REQ-020.

Structure
REQ-028 obi_req_t and obi_resp_t come from obi_pkg; ARB_MODE encodings are localparams in core_v_mini_mcu_pkg.
REQ-029 The ID FIFO is one sub-module, mochila_id_fifo, parametrised by width and depth, with push, pop, full, empty, count and head outputs.
REQ-030 No other sub-modules; total RTL target is 150-300 lines.

Verification
REQ-031 Masters 0 and 2 request continuously, slave gnt=1, ARB_MODE=0 -> grants alternate 0,2,0,2; rvalid is routed in the same order.
REQ-032 Master 1 requests with slave gnt=0 for 3 cycles while master 0 starts requesting in cycle 2 -> slave_req_o holds master 1 addr/wdata stable; master 1 is granted in cycle 4.
REQ-033 MAX_OUTSTANDING=2, slave withholds rvalid, 3 requests -> 2 grants, outstanding_o=2, third request blocked; one rvalid -> third request granted on the next cycle.
REQ-034 Push and pop in the same cycle at count=1 -> outstanding_o stays 1; rdata 0xDEADBEEF reaches the correct master.
REQ-035 rvalid with an empty FIFO -> err_o=1 from the next cycle, no master rvalid; err_o clears only on rst_ni.
REQ-036 ARB_MODE=1, all 3 masters request -> master 0 is always granted; master 2 is granted only when 0 and 1 are idle.
